// File: rtl/shifter_pkg.sv
// shifter_pkg: op encoding and bit-reversal helper shared by the pipelined barrel shifter
package shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    // Widest operand the reversal helper can handle; callers zero-extend into it
    localparam int MAX_WIDTH = 256;
    localparam int MAX_IW    = $clog2(MAX_WIDTH);

    // Reverse the low w bits of d; bits at and above w come back as zero
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] d, input int w);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++)
            if (i < w) r[MAX_IW'(i)] = d[MAX_IW'(w - 1 - i)];
        return r;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: applies shift levels LO..HI to one operand, then holds it in a valid/ready-gated register slice
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int LO    = 0,
    parameter int HI    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_fill,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_op,
    output logic [SHW-1:0]   out_shamt,
    output logic             out_fill,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] lvl [LO:HI+1];

    assign lvl[LO] = in_data;

    // Each level is a right shift by 2^g: rotate wraps the dropped bits, every other op fills
    for (genvar g = LO; g <= HI; g++) begin : g_lvl
        localparam int S = 1 << g;
        assign lvl[g+1] = !in_shamt[g]          ? lvl[g]
                        : (in_op == OP_ROR)     ? {lvl[g][S-1:0], lvl[g][WIDTH-1:S]}
                        :                         {{S{in_fill}}, lvl[g][WIDTH-1:S]};
    end

    // An empty stage always accepts, so bubbles collapse even while downstream stalls
    assign in_ready = !out_valid || out_ready;

    // Capture the upstream slice whenever this stage is empty or its contents move on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_shamt <= '0;
            out_fill  <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            out_op    <= in_op;
            out_shamt <= in_shamt;
            out_fill  <= in_fill;
            out_data  <= lvl[HI+1];
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SLL/SRL/SRA/ROR shifter split across STAGES register slices with valid/ready flow control
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 2,
    localparam int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    if (WIDTH < 8 || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0 || STAGES < 1 || STAGES > SHW) begin : g_bad
        $error("pipelined_barrel_shifter: unsupported WIDTH/STAGES combination");
    end

    // Index 0 is the issue side, index STAGES the output of the last slice
    logic             v    [STAGES+1];
    logic             rdy  [STAGES+1];
    logic [1:0]       op   [STAGES+1];
    logic [SHW-1:0]   sh   [STAGES+1];
    logic             fill [STAGES+1];
    logic [WIDTH-1:0] d    [STAGES+1];

    // SLL rides the right-shift datapath between two reversals; SRA captures its sign once here
    assign v[0]     = in_valid;
    assign op[0]    = in_op;
    assign sh[0]    = in_shamt;
    assign fill[0]  = (in_op == OP_SRA) && in_data[WIDTH-1];
    assign d[0]     = (in_op == OP_SLL) ? WIDTH'(bit_reverse(MAX_WIDTH'(in_data), WIDTH)) : in_data;
    assign in_ready = rdy[0];
    assign rdy[STAGES] = out_ready;

    // Stage g applies shamt bits i with floor(i*STAGES/SHW) == g
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .LO    ((g * SHW + STAGES - 1) / STAGES),
            .HI    (((g + 1) * SHW + STAGES - 1) / STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (v[g]),
            .in_ready  (rdy[g]),
            .in_op     (op[g]),
            .in_shamt  (sh[g]),
            .in_fill   (fill[g]),
            .in_data   (d[g]),
            .out_valid (v[g+1]),
            .out_ready (rdy[g+1]),
            .out_op    (op[g+1]),
            .out_shamt (sh[g+1]),
            .out_fill  (fill[g+1]),
            .out_data  (d[g+1])
        );
    end

    // Reversal preserves zero-ness, so the flag comes straight off the last register
    assign out_valid = v[STAGES];
    assign out_data  = (op[STAGES] == OP_SLL) ? WIDTH'(bit_reverse(MAX_WIDTH'(d[STAGES]), WIDTH)) : d[STAGES];
    assign out_zero  = ~|d[STAGES];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed vectors plus an arithmetic scoreboard over three width/depth configurations
module tb_pipelined_barrel_shifter;

    localparam int NC = 3;
    localparam int CW [NC] = '{32, 64, 8};
    localparam int CS [NC] = '{2, 3, 1};

    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  sh;
        logic [63:0] d;
        logic [63:0] e;
    } vec_t;

    localparam vec_t DV [13] = '{
        '{2'd0, 6'd3,  64'd31,           64'd248},
        '{2'd1, 6'd3,  64'd31,           64'd3},
        '{2'd0, 6'd31, 64'd127,          64'h8000_0000},
        '{2'd1, 6'd31, 64'd127,          64'd0},
        '{2'd2, 6'd31, 64'h8000_0000,    64'hFFFF_FFFF},
        '{2'd3, 6'd10, 64'd26,           64'h0680_0000},
        '{2'd0, 6'd0,  64'd127,          64'd127},
        '{2'd0, 6'd12, 64'd0,            64'd0},
        '{2'd2, 6'd4,  64'h8000_0000,    64'hF800_0000},
        '{2'd2, 6'd4,  64'h7000_0000,    64'h0700_0000},
        '{2'd2, 6'd0,  64'h8000_0000,    64'h8000_0000},
        '{2'd3, 6'd0,  64'hDEAD_BEEF,    64'hDEAD_BEEF},
        '{2'd3, 6'd4,  64'h0000_00AB,    64'hB000_000A}
    };

    localparam vec_t BP [6] = '{
        '{2'd0, 6'd1,  64'd1,            64'd2},
        '{2'd1, 6'd4,  64'h100,          64'h10},
        '{2'd2, 6'd8,  64'h8000_0000,    64'hFF80_0000},
        '{2'd3, 6'd16, 64'h1234_5678,    64'h5678_1234},
        '{2'd0, 6'd31, 64'd1,            64'h8000_0000},
        '{2'd1, 6'd0,  64'hCAFE_F00D,    64'hCAFE_F00D}
    };

    logic        clk;
    logic        rst_n;
    logic        iv   [NC];
    logic        ir   [NC];
    logic [1:0]  iop  [NC];
    logic [5:0]  ish  [NC];
    logic [63:0] idat [NC];
    logic        ov   [NC];
    logic        ordy [NC];
    logic [63:0] odat [NC];
    logic        oz   [NC];

    int nchk = 0;
    int nerr = 0;
    int nout [NC];
    logic [63:0] expq [NC][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_cfg
        localparam int W  = CW[g];
        localparam int SW = $clog2(W);
        logic [W-1:0] od;
        pipelined_barrel_shifter #(.WIDTH(W), .STAGES(CS[g])) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_op     (iop[g]),
            .in_shamt  (ish[g][SW-1:0]),
            .in_data   (idat[g][W-1:0]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od),
            .out_zero  (oz[g])
        );
        assign odat[g] = 64'(od);
    end

    // What the op means arithmetically on a w-bit operand
    function automatic logic [63:0] ref_shift(input logic [1:0] op, input int sh, input logic [63:0] d, input int w);
        logic [63:0] m;
        logic [63:0] x;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = d & m;
        case (op)
            2'd0:    return (x << sh) & m;
            2'd1:    return x >> sh;
            2'd2:    return (x >> sh) | ((((x >> (w - 1)) & 64'd1) != 0) ? (m & ~(m >> sh)) : 64'd0);
            default: return (sh == 0) ? x : (((x >> sh) | (x << (w - sh))) & m);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted op queues its expected result, every output transfer must match the head
    initial begin
        logic        stall [NC];
        logic [63:0] pdat  [NC];
        logic        pz    [NC];
        logic [63:0] e;
        for (int c = 0; c < NC; c++) begin
            stall[c] = 1'b0;
            nout[c]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (!rst_n) begin
                    expq[c].delete();
                    stall[c] = 1'b0;
                    chk($sformatf("cfg%0d out_valid in reset", c), 64'(ov[c]), 64'd0);
                end else begin
                    if (stall[c]) begin
                        chk($sformatf("cfg%0d stalled out_valid", c), 64'(ov[c]), 64'd1);
                        chk($sformatf("cfg%0d stalled out_data", c), odat[c], pdat[c]);
                        chk($sformatf("cfg%0d stalled out_zero", c), 64'(oz[c]), 64'(pz[c]));
                    end
                    chk($sformatf("cfg%0d in_ready occ=%0d", c, expq[c].size()), 64'(ir[c]),
                        64'((expq[c].size() < CS[c]) || ordy[c]));
                    if (ov[c] && ordy[c]) begin
                        if (expq[c].size() == 0) begin
                            nchk++;
                            nerr++;
                            $display("FAIL cfg%0d output with nothing pending: got %0h", c, odat[c]);
                        end else begin
                            e = expq[c].pop_front();
                            chk($sformatf("cfg%0d out_data #%0d", c, nout[c]), odat[c], e);
                            chk($sformatf("cfg%0d out_zero #%0d", c, nout[c]), 64'(oz[c]), 64'(e == 64'd0));
                            nout[c]++;
                        end
                    end
                    if (iv[c] && ir[c])
                        expq[c].push_back(ref_shift(iop[c], int'(ish[c]), idat[c], CW[c]));
                    stall[c] = ov[c] && !ordy[c];
                    pdat[c]  = odat[c];
                    pz[c]    = oz[c];
                end
            end
        end
    end

    // Single op on an empty pipe with out_ready high: result must show exactly CS[c] cycles after acceptance
    task automatic op1(input int c, input vec_t t, input string nm);
        iop[c]  = t.op;
        ish[c]  = t.sh;
        idat[c] = t.d;
        iv[c]   = 1'b1;
        @(negedge clk);
        chk({nm, " in_ready"}, 64'(ir[c]), 64'd1);
        @(posedge clk);
        #1 iv[c] = 1'b0;
        for (int k = 1; k < CS[c]; k++) begin
            @(negedge clk);
            chk({nm, " early out_valid"}, 64'(ov[c]), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk({nm, " out_valid"}, 64'(ov[c]), 64'd1);
        chk({nm, " out_data"}, odat[c], t.e);
        chk({nm, " out_zero"}, 64'(oz[c]), 64'(t.e == 64'd0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int n0;
        rst_n = 1'b0;
        for (int c = 0; c < NC; c++) begin
            iv[c]   = 1'b0;
            ordy[c] = 1'b1;
            iop[c]  = '0;
            ish[c]  = '0;
            idat[c] = '0;
        end

        // Model pins
        chk("model ror", ref_shift(2'd3, 10, 64'd26, 32), 64'h0680_0000);
        chk("model sra64", ref_shift(2'd2, 63, 64'h8000_0000_0000_0000, 64), '1);
        chk("model sll8", ref_shift(2'd0, 3, 64'd31, 8), 64'd248);

        repeat (2) @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("cfg%0d reset out_data", c), odat[c], 64'd0);
            chk($sformatf("cfg%0d reset out_zero", c), 64'(oz[c]), 64'd1);
            chk($sformatf("cfg%0d reset in_ready", c), 64'(ir[c]), 64'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single ops, default configuration
        for (int i = 0; i < 13; i++)
            op1(0, DV[i], $sformatf("dv%0d", i));

        // Back-to-back stream with a four-cycle output stall
        sent = 0;
        n0 = nout[0];
        for (int t = 0; t < 20; t++) begin
            ordy[0] = !(t >= 3 && t < 7);
            iv[0]   = sent < 6;
            if (sent < 6) begin
                iop[0]  = BP[sent].op;
                ish[0]  = BP[sent].sh;
                idat[0] = BP[sent].d;
            end
            @(negedge clk);
            if (t == 4 || t == 6) begin
                chk($sformatf("bp t%0d in_ready", t), 64'(ir[0]), 64'd0);
                chk($sformatf("bp t%0d held data", t), odat[0], BP[1].e);
            end
            if (iv[0] && ir[0]) sent++;
            @(posedge clk);
            #1;
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        chk("bp accepted", 64'(sent), 64'd6);
        chk("bp delivered", 64'(nout[0] - n0), 64'd6);

        // Bubble collapse: second op advances behind a stalled first op
        iop[0] = 2'd2; ish[0] = 6'd1; idat[0] = 64'h8000_0000; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(posedge clk);
        #1 ordy[0] = 1'b0;
        iop[0] = 2'd3; ish[0] = 6'd1; idat[0] = 64'd1; iv[0] = 1'b1;
        @(negedge clk);
        chk("bubble in_ready", 64'(ir[0]), 64'd1);
        chk("bubble out_valid", 64'(ov[0]), 64'd1);
        chk("bubble out_data", odat[0], 64'hC000_0000);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(negedge clk);
        chk("full in_ready", 64'(ir[0]), 64'd0);
        chk("full out_data", odat[0], 64'hC000_0000);
        @(posedge clk);
        #1 ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain second valid", 64'(ov[0]), 64'd1);
        chk("drain second data", odat[0], 64'h8000_0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain empty", 64'(ov[0]), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset with two ops in flight
        iop[0] = 2'd0; ish[0] = 6'd1; idat[0] = 64'd1; iv[0] = 1'b1;
        @(posedge clk);
        #1 idat[0] = 64'd2;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(ov[0]), 64'd0);
        chk("async rst out_data", odat[0], 64'd0);
        chk("async rst out_zero", 64'(oz[0]), 64'd1);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post rst out_valid %0d", k), 64'(ov[0]), 64'd0);
        end
        @(posedge clk);
        #1;

        // First scenario and a stalled stream at the other widths/depths
        for (int c = 1; c < NC; c++) begin
            op1(c, DV[0], $sformatf("cfg%0d sll", c));
            op1(c, DV[1], $sformatf("cfg%0d srl", c));
            sent = 0;
            n0 = nout[c];
            for (int t = 0; t < 40; t++) begin
                ordy[c] = (t % 4) != 3;
                iv[c]   = sent < 12;
                iop[c]  = 2'(sent % 4);
                ish[c]  = (sent < 4) ? 6'd1 : (sent < 8) ? 6'(CW[c] - 1) : 6'(CW[c] / 2 + 1);
                idat[c] = 64'hF0E1_D2C3_B4A5_9687 >> sent;
                @(negedge clk);
                if (iv[c] && ir[c]) sent++;
                @(posedge clk);
                #1;
            end
            iv[c] = 1'b0;
            ordy[c] = 1'b1;
            chk($sformatf("cfg%0d stream accepted", c), 64'(sent), 64'd12);
            chk($sformatf("cfg%0d stream delivered", c), 64'(nout[c] - n0), 64'd12);
        end

        repeat (4) @(negedge clk);
        for (int c = 0; c < NC; c++)
            chk($sformatf("cfg%0d pending at end", c), 64'(expq[c].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
